// File: rtl/router_1x3.sv
// router_1x3: byte-serial 1-to-3 packet router with per-destination FIFOs,
// parity checking and per-port read timeout (soft reset).
//
// Source handshake: the router takes data_in at a rising clock edge only if
// busy was low in the cycle before that edge. While busy is high the source
// holds data_in and pkt_valid unchanged. Destination handshake: a byte is
// popped at an edge where read_enb_N is high and vld_out_N is high; the
// popped byte appears on data_out_N after that edge.
module router_1x3 #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       pkt_valid,
  output logic       busy,
  output logic       error,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic [2:0] fsm_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Packet bookkeeping
  logic [1:0] addr_q;
  logic [7:0] hdr_q;   // header held while waiting for the FIFO to empty
  logic [7:0] pend_q;  // payload byte taken while the FIFO was full
  logic [7:0] par_q;   // received parity byte
  logic [7:0] calc_q;  // running XOR of header and payload
  logic       skip_q;  // discarding a packet addressed to port 3
  logic       done_q;  // parity already stored; full-wait has nothing pending

  // FIFO storage and status; index 3 models the non-existent port 3
  logic [7:0]    mem    [3][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [3];
  logic [PW-1:0] rd_ptr [3];
  logic [CW-1:0] count  [3];
  logic [TW-1:0] timer  [3];
  logic [7:0]    dout   [3];
  logic [3:0]    full, empty;
  logic [2:0]    rd_req, rd_fire, wr_fire, flush;

  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  assign rd_req     = {read_enb_2, read_enb_1, read_enb_0};
  assign vld_out_0  = ~empty[0];
  assign vld_out_1  = ~empty[1];
  assign vld_out_2  = ~empty[2];
  assign data_out_0 = dout[0];
  assign data_out_1 = dout[1];
  assign data_out_2 = dout[2];
  assign fsm_state  = state_q;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= DECODE_ADDRESS;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS:
        if (pkt_valid && !skip_q && data_in[1:0] != 2'd3)
          state_d = empty[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (empty[addr_q]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        state_d = LOAD_DATA;
      LOAD_DATA:
        if (!pkt_valid)          state_d = LOAD_PARITY;
        else if (full[addr_q])   state_d = FIFO_FULL_STATE;
      FIFO_FULL_STATE:
        if (!full[addr_q]) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (done_q)         state_d = DECODE_ADDRESS;
        else if (pkt_valid) state_d = LOAD_DATA;
        else                state_d = LOAD_PARITY;
      LOAD_PARITY:
        if (!full[addr_q]) state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = full[addr_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        state_d = DECODE_ADDRESS;
    endcase
  end

  // FSM outputs: busy and the FIFO write request
  always_comb begin
    busy    = 1'b1;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    wr_data = data_in;
    case (state_q)
      DECODE_ADDRESS: begin
        busy    = 1'b0;
        wr_addr = data_in[1:0];
        wr_en   = pkt_valid && !skip_q && data_in[1:0] != 2'd3 && empty[data_in[1:0]];
      end
      WAIT_TILL_EMPTY: begin
        wr_data = hdr_q;
        wr_en   = empty[addr_q];
      end
      LOAD_DATA: begin
        busy  = 1'b0;
        wr_en = pkt_valid && !full[addr_q];
      end
      LOAD_AFTER_FULL: begin
        wr_data = pend_q;
        wr_en   = !done_q;
      end
      LOAD_PARITY: begin
        wr_data = par_q;
        wr_en   = !full[addr_q];
      end
      default: ;
    endcase
  end

  // Packet registers: address, held bytes, parity accumulation and error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      hdr_q  <= '0;
      pend_q <= '0;
      par_q  <= '0;
      calc_q <= '0;
      skip_q <= 1'b0;
      done_q <= 1'b0;
      error  <= 1'b0;
    end else begin
      if (!pkt_valid) skip_q <= 1'b0;
      case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid && !skip_q) begin
            if (data_in[1:0] == 2'd3) begin
              skip_q <= 1'b1;
            end else begin
              addr_q <= data_in[1:0];
              hdr_q  <= data_in;
              calc_q <= data_in;
              done_q <= 1'b0;
              error  <= 1'b0;
            end
          end
        LOAD_DATA:
          if (!pkt_valid)          par_q  <= data_in;
          else if (full[addr_q])   pend_q <= data_in;
          else                     calc_q <= calc_q ^ data_in;
        LOAD_AFTER_FULL:
          if (!done_q) begin
            calc_q <= calc_q ^ pend_q;
            if (!pkt_valid) par_q <= data_in;
          end
        CHECK_PARITY_ERROR: begin
          error <= (calc_q != par_q);
          if (full[addr_q]) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FIFO status and per-port read/write/flush qualifiers
  always_comb begin
    full[3]  = 1'b1;
    empty[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      full[i]    = (count[i] == CW'(FIFO_DEPTH));
      empty[i]   = (count[i] == '0);
      rd_fire[i] = rd_req[i] && !empty[i];
      wr_fire[i] = wr_en && (wr_addr == 2'(i)) && !full[i];
      flush[i]   = !empty[i] && !rd_req[i] && (timer[i] == TW'(TIMEOUT - 1));
    end
  end

  // FIFO storage, pointers, registered read data and unread timeout
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset || flush[i]) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        timer[i]  <= '0;
        dout[i]   <= '0;
      end else begin
        if (wr_fire[i]) begin
          mem[i][wr_ptr[i]] <= wr_data;
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (rd_fire[i]) begin
          dout[i]   <= mem[i][rd_ptr[i]];
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        if (wr_fire[i] && !rd_fire[i])      count[i] <= count[i] + 1'b1;
        else if (rd_fire[i] && !wr_fire[i]) count[i] <= count[i] - 1'b1;
        if (!empty[i] && !rd_req[i]) timer[i] <= timer[i] + 1'b1;
        else                         timer[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_1x3.sv
// tb_router_1x3: directed bench for router_1x3 with immediate-assertion checks.
module tb_router_1x3;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       busy, error;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic [2:0] fsm_state;

  int checks = 0;
  int errors = 0;

  router_1x3 dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .pkt_valid  (pkt_valid),
    .busy       (busy),
    .error      (error),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .fsm_state  (fsm_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one source byte and hold it until the router takes it
  task automatic send_byte(input logic [7:0] b, input logic v);
    int n;
    n = 0;
    data_in   = b;
    pkt_valid = v;
    while (busy === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("send_not_stalled", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic idle(input int n);
    data_in   = 8'h00;
    pkt_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Pop one byte from a port and compare the registered output
  task automatic pop(input int port, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    case (port)
      0:       read_enb_0 = 1'b1;
      1:       read_enb_1 = 1'b1;
      default: read_enb_2 = 1'b1;
    endcase
    tick();
    read_enb_0 = 1'b0;
    read_enb_1 = 1'b0;
    read_enb_2 = 1'b0;
    case (port)
      0:       got = data_out_0;
      1:       got = data_out_1;
      default: got = data_out_2;
    endcase
    chk(tag, {24'd0, got}, {24'd0, exp});
  endtask

  logic [7:0] stream [22];
  logic [7:0] par;
  int         idx, rd_idx;
  logic       acc, popped;

  initial begin
    reset      = 1'b1;
    data_in    = 8'h00;
    pkt_valid  = 1'b0;
    read_enb_0 = 1'b0;
    read_enb_1 = 1'b0;
    read_enb_2 = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_vld",   {29'd0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    chk("rst_dout",  {8'd0, data_out_2, data_out_1, data_out_0}, 32'd0);
    chk("rst_state", {29'd0, fsm_state}, 32'd0);

    // Good packet to port 0: header 0C, payload 11 22 33, parity 0C
    send_byte(8'h0C, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h0C, 1'b0);
    idle(2);
    chk("p0_vld",   {31'd0, vld_out_0}, 32'd1);
    chk("p0_error", {31'd0, error},     32'd0);
    chk("p0_busy",  {31'd0, busy},      32'd0);
    pop(0, 8'h0C, "p0_b0");
    pop(0, 8'h11, "p0_b1");
    pop(0, 8'h22, "p0_b2");
    pop(0, 8'h33, "p0_b3");
    pop(0, 8'h0C, "p0_b4");
    chk("p0_drained", {31'd0, vld_out_0}, 32'd0);

    // Same packet with a wrong parity byte
    send_byte(8'h0C, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'hFF, 1'b0);
    idle(1);
    chk("perr_early", {31'd0, error}, 32'd0);
    idle(1);
    chk("perr_set", {31'd0, error}, 32'd1);
    pop(0, 8'h0C, "perr_b0");
    pop(0, 8'h11, "perr_b1");
    pop(0, 8'h22, "perr_b2");
    pop(0, 8'h33, "perr_b3");
    pop(0, 8'hFF, "perr_b4");
    chk("perr_hold", {31'd0, error}, 32'd1);

    // Port 1, L=20, no reads until the FIFO has filled and stalled the source
    stream[0] = 8'h51;
    par = 8'h51;
    for (int k = 1; k <= 20; k++) begin
      stream[k] = 8'(k);
      par = par ^ 8'(k);
    end
    stream[21] = par;
    idx = 0;
    rd_idx = 0;
    for (int cyc = 0; cyc < 200 && rd_idx < 22; cyc++) begin
      if (cyc == 22) begin
        chk("full_busy",  {31'd0, busy},      32'd1);
        chk("full_state", {29'd0, fsm_state}, 32'd4);
        chk("full_vld1",  {31'd0, vld_out_1}, 32'd1);
      end
      if (idx < 22) begin
        data_in   = stream[idx];
        pkt_valid = (idx < 21);
      end else begin
        data_in   = 8'h00;
        pkt_valid = 1'b0;
      end
      read_enb_1 = (cyc >= 22);
      acc    = (idx < 22) && !busy;
      popped = read_enb_1 && vld_out_1;
      tick();
      if (acc) idx++;
      if (popped) begin
        chk("p1_stream", {24'd0, data_out_1}, {24'd0, stream[rd_idx]});
        rd_idx++;
      end
      if (cyc == 0) chk("hdr_clears_error", {31'd0, error}, 32'd0);
    end
    read_enb_1 = 1'b0;
    data_in    = 8'h00;
    pkt_valid  = 1'b0;
    chk("p1_count",    32'(rd_idx), 32'd22);
    chk("p1_error",    {31'd0, error},     32'd0);
    chk("p1_vld_done", {31'd0, vld_out_1}, 32'd0);

    // Port 2: second packet waits until the first has been drained
    send_byte(8'h06, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAC, 1'b0);
    idle(2);
    send_byte(8'h06, 1'b1);
    data_in   = 8'h55;
    pkt_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("wte_busy",  {31'd0, busy},      32'd1);
      chk("wte_state", {29'd0, fsm_state}, 32'd1);
      tick();
    end
    pop(2, 8'h06, "p2a_b0");
    pop(2, 8'hAA, "p2a_b1");
    pop(2, 8'hAC, "p2a_b2");
    send_byte(8'h55, 1'b1);
    send_byte(8'h53, 1'b0);
    idle(2);
    chk("p2b_error", {31'd0, error}, 32'd0);
    pop(2, 8'h06, "p2b_b0");
    pop(2, 8'h55, "p2b_b1");
    pop(2, 8'h53, "p2b_b2");
    chk("p2b_drained", {31'd0, vld_out_2}, 32'd0);

    // Unread timeout on port 0
    send_byte(8'h04, 1'b1);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h7A, 1'b0);
    idle(2);
    pop(0, 8'h04, "to_b0");
    repeat (29) tick();
    chk("to_vld_before", {31'd0, vld_out_0}, 32'd1);
    chk("to_dout_hold",  {24'd0, data_out_0}, 32'h04);
    tick();
    chk("to_vld_after",  {31'd0, vld_out_0}, 32'd0);
    chk("to_dout_clear", {24'd0, data_out_0}, 32'd0);

    // Header for port 3: whole packet ignored
    send_byte(8'h0B, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h08, 1'b0);
    idle(2);
    chk("a3_vld",   {29'd0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    chk("a3_state", {29'd0, fsm_state}, 32'd0);

    // Bad-parity packet to port 0, then reset in the middle of the next packet
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    idle(2);
    chk("pre_rst_error", {31'd0, error},     32'd1);
    chk("pre_rst_vld0",  {31'd0, vld_out_0}, 32'd1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h10, 1'b1);
    chk("mid_state", {29'd0, fsm_state}, 32'd3);
    reset = 1'b1;
    tick();
    chk("mrst_vld",   {29'd0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    chk("mrst_dout",  {8'd0, data_out_2, data_out_1, data_out_0}, 32'd0);
    chk("mrst_busy",  {31'd0, busy},      32'd0);
    chk("mrst_error", {31'd0, error},     32'd0);
    chk("mrst_state", {29'd0, fsm_state}, 32'd0);
    reset     = 1'b0;
    data_in   = 8'h00;
    pkt_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
